// File: rtl/packet_length_tagger.sv
// Packet length tagger: zero-latency AXI-Stream body passthrough that measures
// each packet from tkeep and queues a length/status descriptor per packet into
// a first-word-fall-through descriptor FIFO, with running packet/byte counters.
module packet_length_tagger #(
  parameter int DW         = 128,
  parameter int LEN_W      = 16,
  parameter int DESC_DEPTH = 8,
  parameter int MIN_LEN    = 64,
  parameter int MAX_LEN    = 1518
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          stat_clear,
  input  logic [DW-1:0]                 axis_in_tdata,
  input  logic [DW/8-1:0]               axis_in_tkeep,
  input  logic                          axis_in_tlast,
  input  logic                          axis_in_tvalid,
  output logic                          axis_in_tready,
  output logic [DW-1:0]                 axis_body_tdata,
  output logic [DW/8-1:0]               axis_body_tkeep,
  output logic                          axis_body_tlast,
  output logic                          axis_body_tvalid,
  input  logic                          axis_body_tready,
  output logic [LEN_W+2:0]              axis_desc_tdata,
  output logic                          axis_desc_tvalid,
  input  logic                          axis_desc_tready,
  output logic [$clog2(DESC_DEPTH):0]   desc_level,
  output logic [31:0]                   pkt_count,
  output logic [31:0]                   byte_count
);

  localparam int KW     = DW / 8;
  localparam int CW     = $clog2(KW + 1);
  localparam int AW     = $clog2(DESC_DEPTH);
  localparam int DESC_W = LEN_W + 3;

  localparam logic [AW:0]      DEPTH_C   = (AW + 1)'(DESC_DEPTH);
  localparam logic [AW:0]      ONE_C     = (AW + 1)'(1);
  localparam logic [AW-1:0]    PTR_ONE_C = AW'(1);
  localparam logic [31:0]      MIN_LEN_C = 32'(MIN_LEN);
  localparam logic [31:0]      MAX_LEN_C = 32'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_SAT_C = {LEN_W{1'b1}};

  // Number of asserted byte enables; position of the bits does not matter.
  function automatic logic [CW-1:0] popcount(input logic [KW-1:0] keep);
    logic [CW-1:0] cnt;
    cnt = {CW{1'b0}};
    for (int i = 0; i < KW; i++) begin
      cnt = cnt + CW'(keep[i]);
    end
    return cnt;
  endfunction

  // Packet accumulation state
  logic [LEN_W-1:0]  len_acc_q, len_acc_d;
  logic              sat_sticky_q, sat_sticky_d;
  logic              null_sticky_q, null_sticky_d;

  // Descriptor FIFO state
  logic [DESC_W-1:0] mem_q [DESC_DEPTH];
  logic [DESC_W-1:0] mem_d [DESC_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;

  // Statistics state
  logic [31:0]       pkt_count_q, pkt_count_d;
  logic [31:0]       byte_count_q, byte_count_d;

  // Combinational datapath signals
  logic              desc_full_s;
  logic              desc_empty_s;
  logic              stall_s;
  logic              acc_s;
  logic              push_s;
  logic              pop_s;
  logic [CW-1:0]     beat_bytes_s;
  logic              zero_beat_s;
  logic [LEN_W:0]    sum_ext_s;
  logic              sat_now_s;
  logic [LEN_W-1:0]  len_now_s;
  logic [31:0]       len_now_ext_s;
  logic              runt_s;
  logic              giant_s;
  logic              null_s;
  logic [DESC_W-1:0] desc_new_s;

  // Handshake, passthrough and per-beat length arithmetic. The stall looks only
  // at the registered occupancy, so a same-cycle pop never frees a slot early.
  always_comb begin
    desc_full_s      = (count_q == DEPTH_C);
    desc_empty_s     = (count_q == {(AW + 1){1'b0}});
    stall_s          = axis_in_tlast & desc_full_s;

    axis_body_tdata  = axis_in_tdata;
    axis_body_tkeep  = axis_in_tkeep;
    axis_body_tlast  = axis_in_tlast;
    axis_body_tvalid = axis_in_tvalid & ~stall_s;
    axis_in_tready   = axis_body_tready & ~stall_s;

    acc_s            = axis_in_tvalid & axis_in_tready;
    push_s           = acc_s & axis_in_tlast;
    pop_s            = ~desc_empty_s & axis_desc_tready;

    beat_bytes_s     = popcount(axis_in_tkeep);
    zero_beat_s      = (beat_bytes_s == {CW{1'b0}});
    sum_ext_s        = {1'b0, len_acc_q} + (LEN_W + 1)'(beat_bytes_s);
    sat_now_s        = sum_ext_s[LEN_W];
    if (sat_now_s) begin
      len_now_s = LEN_SAT_C;
    end else begin
      len_now_s = sum_ext_s[LEN_W-1:0];
    end
    len_now_ext_s    = 32'(len_now_s);

    runt_s           = (len_now_ext_s < MIN_LEN_C);
    giant_s          = (len_now_ext_s > MAX_LEN_C) | sat_sticky_q | sat_now_s;
    null_s           = null_sticky_q | zero_beat_s;
    desc_new_s       = {null_s, giant_s, runt_s, len_now_s};
  end

  // Next-state for the per-packet accumulator and its sticky status flags.
  always_comb begin
    len_acc_d     = len_acc_q;
    sat_sticky_d  = sat_sticky_q;
    null_sticky_d = null_sticky_q;
    if (acc_s) begin
      if (axis_in_tlast) begin
        len_acc_d     = {LEN_W{1'b0}};
        sat_sticky_d  = 1'b0;
        null_sticky_d = 1'b0;
      end else begin
        len_acc_d     = len_now_s;
        sat_sticky_d  = sat_sticky_q | sat_now_s;
        null_sticky_d = null_sticky_q | zero_beat_s;
      end
    end else begin
      len_acc_d     = len_acc_q;
    end
  end

  // Next-state for the descriptor FIFO; a push during a pop lands behind the head.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = desc_new_s;
      wr_ptr_d        = wr_ptr_q + PTR_ONE_C;
    end else begin
      wr_ptr_d        = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE_C;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  // Next-state for the statistics counters; a clear wins over any increment.
  always_comb begin
    pkt_count_d  = pkt_count_q;
    byte_count_d = byte_count_q;
    if (stat_clear) begin
      pkt_count_d  = 32'd0;
      byte_count_d = 32'd0;
    end else if (acc_s) begin
      byte_count_d = byte_count_q + 32'(beat_bytes_s);
      if (axis_in_tlast) begin
        pkt_count_d = pkt_count_q + 32'd1;
      end else begin
        pkt_count_d = pkt_count_q;
      end
    end else begin
      pkt_count_d  = pkt_count_q;
    end
  end

  // State registers with synchronous active-low reset; reset drops any partial packet.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      len_acc_q     <= {LEN_W{1'b0}};
      sat_sticky_q  <= 1'b0;
      null_sticky_q <= 1'b0;
      mem_q         <= '{default: {DESC_W{1'b0}}};
      wr_ptr_q      <= {AW{1'b0}};
      rd_ptr_q      <= {AW{1'b0}};
      count_q       <= {(AW + 1){1'b0}};
      pkt_count_q   <= 32'd0;
      byte_count_q  <= 32'd0;
    end else begin
      len_acc_q     <= len_acc_d;
      sat_sticky_q  <= sat_sticky_d;
      null_sticky_q <= null_sticky_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      pkt_count_q   <= pkt_count_d;
      byte_count_q  <= byte_count_d;
    end
  end

  // Descriptor port and status outputs, all taken straight from registers.
  always_comb begin
    axis_desc_tvalid = ~desc_empty_s;
    axis_desc_tdata  = mem_q[rd_ptr_q];
    desc_level       = count_q;
    pkt_count        = pkt_count_q;
    byte_count       = byte_count_q;
  end

endmodule

// File: tb/tb_packet_length_tagger.sv
// Testbench for packet_length_tagger: directed packets checked every cycle
// against a queue-based packet model, plus literal expectations at key points.
module tb_packet_length_tagger;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         stat_clear = 1'b0;
  logic [127:0] in_tdata = '0;
  logic [15:0]  in_tkeep = '0;
  logic         in_tlast = 1'b0;
  logic         in_tvalid = 1'b0;
  logic         axis_in_tready;
  logic [127:0] axis_body_tdata;
  logic [15:0]  axis_body_tkeep;
  logic         axis_body_tlast;
  logic         axis_body_tvalid;
  logic         body_tready = 1'b1;
  logic [18:0]  axis_desc_tdata;
  logic         axis_desc_tvalid;
  logic         desc_tready = 1'b0;
  logic [3:0]   desc_level;
  logic [31:0]  pkt_count;
  logic [31:0]  byte_count;

  // Second instance with an 8-bit length field for saturation
  logic [15:0]  in8_tkeep = '0;
  logic         in8_tlast = 1'b0;
  logic         in8_tvalid = 1'b0;
  logic         in8_tready;
  logic [127:0] body8_tdata;
  logic [15:0]  body8_tkeep;
  logic         body8_tlast;
  logic         body8_tvalid;
  logic         body8_tready = 1'b1;
  logic [10:0]  desc8_tdata;
  logic         desc8_tvalid;
  logic         desc8_tready = 1'b0;
  logic [3:0]   desc8_level;
  logic [31:0]  pkt8_count;
  logic [31:0]  byte8_count;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  // Model state
  logic [18:0] m_q[$];
  int          m_sum;
  bit          m_null;
  logic [31:0] m_pkt;
  logic [31:0] m_byte;

  packet_length_tagger #(.DW(128), .LEN_W(16), .DESC_DEPTH(8), .MIN_LEN(64), .MAX_LEN(1518)) u_dut (
    .clk(clk), .resetn(resetn), .stat_clear(stat_clear),
    .axis_in_tdata(in_tdata), .axis_in_tkeep(in_tkeep), .axis_in_tlast(in_tlast),
    .axis_in_tvalid(in_tvalid), .axis_in_tready(axis_in_tready),
    .axis_body_tdata(axis_body_tdata), .axis_body_tkeep(axis_body_tkeep),
    .axis_body_tlast(axis_body_tlast), .axis_body_tvalid(axis_body_tvalid),
    .axis_body_tready(body_tready),
    .axis_desc_tdata(axis_desc_tdata), .axis_desc_tvalid(axis_desc_tvalid),
    .axis_desc_tready(desc_tready), .desc_level(desc_level),
    .pkt_count(pkt_count), .byte_count(byte_count)
  );

  packet_length_tagger #(.DW(128), .LEN_W(8), .DESC_DEPTH(8), .MIN_LEN(64), .MAX_LEN(1518)) u_dut8 (
    .clk(clk), .resetn(resetn), .stat_clear(stat_clear),
    .axis_in_tdata(in_tdata), .axis_in_tkeep(in8_tkeep), .axis_in_tlast(in8_tlast),
    .axis_in_tvalid(in8_tvalid), .axis_in_tready(in8_tready),
    .axis_body_tdata(body8_tdata), .axis_body_tkeep(body8_tkeep),
    .axis_body_tlast(body8_tlast), .axis_body_tvalid(body8_tvalid),
    .axis_body_tready(body8_tready),
    .axis_desc_tdata(desc8_tdata), .axis_desc_tvalid(desc8_tvalid),
    .axis_desc_tready(desc8_tready), .desc_level(desc8_level),
    .pkt_count(pkt8_count), .byte_count(byte8_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Descriptor implied by a packet of true byte total tsum.
  function automatic logic [18:0] model_desc(input int tsum, input bit nul);
    int len;
    len = (tsum > 65535) ? 65535 : tsum;
    return {nul, (tsum > 1518), (len < 64), 16'(len)};
  endfunction

  task automatic model_step();
    int bb;
    int tsum;
    bit stall_m;
    bit acc_m;
    bit pop_m;
    if (!resetn) begin
      m_q.delete();
      m_sum  = 0;
      m_null = 1'b0;
      m_pkt  = 32'd0;
      m_byte = 32'd0;
    end else begin
      bb      = $countones(in_tkeep);
      stall_m = in_tlast && (m_q.size() == 8);
      acc_m   = in_tvalid && body_tready && !stall_m;
      pop_m   = (m_q.size() != 0) && desc_tready;
      if (pop_m) void'(m_q.pop_front());
      if (acc_m) begin
        tsum = m_sum + bb;
        if (in_tlast) begin
          m_q.push_back(model_desc(tsum, m_null || (bb == 0)));
          m_sum  = 0;
          m_null = 1'b0;
        end else begin
          m_sum  = tsum;
          m_null = m_null || (bb == 0);
        end
      end
      if (stat_clear) begin
        m_pkt  = 32'd0;
        m_byte = 32'd0;
      end else if (acc_m) begin
        m_byte = m_byte + 32'(bb);
        if (in_tlast) m_pkt = m_pkt + 32'd1;
      end
    end
  endtask

  // Advance the model on every clock edge.
  always @(posedge clk) model_step();

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    bit exp_stall;
    if (chk_en) begin
      exp_stall = in_tlast && (m_q.size() == 8);
      chk("in_tready", axis_in_tready, body_tready && !exp_stall);
      chk("body_tvalid", axis_body_tvalid, in_tvalid && !exp_stall);
      chk("body_tdata", axis_body_tdata, in_tdata);
      chk("body_tkeep", axis_body_tkeep, in_tkeep);
      chk("body_tlast", axis_body_tlast, in_tlast);
      chk("desc_tvalid", axis_desc_tvalid, m_q.size() != 0);
      chk("desc_level", desc_level, m_q.size());
      if (m_q.size() != 0) chk("desc_head", axis_desc_tdata, m_q[0]);
      chk("pkt_count", pkt_count, m_pkt);
      chk("byte_count", byte_count, m_byte);
    end
  end

  task automatic send_beat(input logic [15:0] k, input logic l);
    bit ok;
    ok = 1'b0;
    in_tvalid = 1'b1;
    in_tkeep  = k;
    in_tlast  = l;
    in_tdata  = {$urandom, $urandom, $urandom, $urandom};
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk);
      ok = axis_in_tready;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("send_timeout", 1'b0, 1'b1);
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    desc_tready = 1'b1;
    for (int n = 0; n < 40 && !done; n++) begin
      @(posedge clk);
      #1;
      done = !axis_desc_tvalid;
    end
    if (!done) chk("drain_timeout", 1'b0, 1'b1);
    desc_tready = 1'b0;
  endtask

  initial begin
    logic [15:0] k;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_level", desc_level, 4'd0);
    chk("reset_tvalid", axis_desc_tvalid, 1'b0);
    chk("reset_pkt", pkt_count, 32'd0);
    @(posedge clk);
    #1;

    // 3 full beats + 8-byte last beat: 56 bytes, runt
    repeat (3) send_beat(16'hFFFF, 1'b0);
    send_beat(16'h00FF, 1'b1);
    @(negedge clk);
    chk("t1_desc", axis_desc_tdata, 19'h10038);
    chk("t1_pkt", pkt_count, 32'd1);
    chk("t1_byte", byte_count, 32'd56);
    @(posedge clk); #1;
    drain();

    // 1600-byte giant, then exactly 64 bytes
    repeat (99) send_beat(16'hFFFF, 1'b0);
    send_beat(16'hFFFF, 1'b1);
    @(negedge clk);
    chk("t2_giant", axis_desc_tdata, 19'h20640);
    @(posedge clk); #1;
    drain();
    repeat (3) send_beat(16'hFFFF, 1'b0);
    send_beat(16'hFFFF, 1'b1);
    @(negedge clk);
    chk("t2_min", axis_desc_tdata, 19'h00040);
    @(posedge clk); #1;
    drain();

    // Zero-keep middle beat, held under body backpressure first
    send_beat(16'hFFFF, 1'b0);
    body_tready = 1'b0;
    in_tvalid = 1'b1; in_tkeep = 16'h0000; in_tlast = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    body_tready = 1'b1;
    send_beat(16'h0000, 1'b0);
    send_beat(16'h000F, 1'b1);
    @(negedge clk);
    chk("t3_null", axis_desc_tdata, 19'h50014);
    @(posedge clk); #1;
    drain();
    send_beat(16'hFFFF, 1'b1);
    @(negedge clk);
    chk("t3_after", axis_desc_tdata, 19'h10010);
    @(posedge clk); #1;
    drain();

    // Fill FIFO to depth, 9th tlast beat must stall until a slot is freed
    for (int i = 0; i < 8; i++) begin
      k = 16'((32'd1 << (i + 1)) - 32'd1);
      send_beat(k, 1'b1);
    end
    in_tvalid = 1'b1; in_tkeep = 16'h01FF; in_tlast = 1'b1;
    @(negedge clk);
    chk("t4_level_full", desc_level, 4'd8);
    chk("t4_stall_ready", axis_in_tready, 1'b0);
    chk("t4_stall_valid", axis_body_tvalid, 1'b0);
    @(posedge clk); #1;
    desc_tready = 1'b1;
    @(negedge clk);
    chk("t4_pop_no_release", axis_in_tready, 1'b0);
    @(posedge clk); #1;
    desc_tready = 1'b0;
    @(negedge clk);
    chk("t4_released", axis_in_tready, 1'b1);
    chk("t4_head2", axis_desc_tdata, 19'h10002);
    @(posedge clk); #1;
    in_tvalid = 1'b0; in_tlast = 1'b0;
    @(negedge clk);
    chk("t4_level_after", desc_level, 4'd8);
    @(posedge clk); #1;
    drain();

    // stat_clear on the same cycle as a tlast acceptance
    send_beat(16'hFFFF, 1'b1);
    stat_clear = 1'b1;
    send_beat(16'h00FF, 1'b1);
    stat_clear = 1'b0;
    @(negedge clk);
    chk("t5_pkt", pkt_count, 32'd0);
    chk("t5_byte", byte_count, 32'd0);
    chk("t5_level", desc_level, 4'd2);
    @(posedge clk); #1;

    // Reset mid-packet, then a fresh 4-byte packet
    send_beat(16'hFFFF, 1'b0);
    send_beat(16'hFFFF, 1'b0);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    send_beat(16'h000F, 1'b1);
    @(negedge clk);
    chk("t6_desc", axis_desc_tdata, 19'h10004);
    chk("t6_level", desc_level, 4'd1);
    chk("t6_pkt", pkt_count, 32'd1);
    chk("t6_byte", byte_count, 32'd4);
    @(posedge clk); #1;
    drain();

    // LEN_W=8 instance: 320 bytes saturate to 255 and flag giant
    in8_tvalid = 1'b1; in8_tkeep = 16'hFFFF; in8_tlast = 1'b0;
    @(negedge clk);
    chk("t7_ready", in8_tready, 1'b1);
    for (int i = 0; i < 19; i++) begin @(posedge clk); #1; end
    in8_tlast = 1'b1;
    @(posedge clk); #1;
    in8_tvalid = 1'b0; in8_tlast = 1'b0;
    @(negedge clk);
    chk("t7_sat", desc8_tdata, 11'h2FF);
    chk("t7_level", desc8_level, 4'd1);
    @(posedge clk); #1;
    in8_tvalid = 1'b1; in8_tkeep = 16'h0003; in8_tlast = 1'b1;
    desc8_tready = 1'b1;
    @(posedge clk); #1;
    in8_tvalid = 1'b0; in8_tlast = 1'b0; desc8_tready = 1'b0;
    @(negedge clk);
    chk("t7_next", desc8_tdata, 11'h102);
    chk("t7_level2", desc8_level, 4'd1);
    chk("t7_pkt", pkt8_count, 32'd2);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/packet_length_tagger.md
Name: packet_length_tagger

Overview:
- Second-generation AXI-Stream packet analyzer.
- Passes the packet body through with zero latency while accumulating each packet's byte count from tkeep.
- On the final beat of each packet, pushes a length/status descriptor into an internal descriptor FIFO. The FIFO decouples the descriptor consumer from the body path, so descriptors are never dropped.
- Adds runt/giant classification, saturating length, zero-keep beat detection and running statistics counters.
- Sits between the RX datapath and the packet-buffer/DMA descriptor logic.

Parameters:
- DW, 128: body data width in bits; multiple of 8, ≥ 8.
- LEN_W, 16: width of the packet length field.
- DESC_DEPTH, 8: descriptor FIFO depth; power of 2, ≥ 2.
- MIN_LEN, 64: packets shorter than this many bytes are flagged runt.
- MAX_LEN, 1518: packets longer than this many bytes are flagged giant.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- stat_clear  in  1  synchronous clear of the statistics counters.
- axis_in_tdata  in  DW  input body data.
- axis_in_tkeep  in  DW/8  input byte enables.
- axis_in_tlast  in  1  last beat of packet.
- axis_in_tvalid  in  1  input valid.
- axis_in_tready  out  1  input ready.
- axis_body_tdata  out  DW  passthrough data.
- axis_body_tkeep  out  DW/8  passthrough byte enables.
- axis_body_tlast  out  1  passthrough last.
- axis_body_tvalid  out  1  passthrough valid.
- axis_body_tready  in  1  downstream ready.
- axis_desc_tdata  out  LEN_W+3  descriptor: [LEN_W-1:0] length, [LEN_W] runt, [LEN_W+1] giant, [LEN_W+2] null_beat.
- axis_desc_tvalid  out  1  descriptor valid.
- axis_desc_tready  in  1  descriptor ready.
- desc_level  out  clog2(DESC_DEPTH)+1  current FIFO occupancy.
- pkt_count  out  32  completed packets.
- byte_count  out  32  accepted bytes.

Behaviour:
- Reset (resetn=0 at posedge): accumulator=0; sticky flags=0; FIFO emptied (desc_level=0, axis_desc_tvalid=0); pkt_count=0; byte_count=0.
  - Reset mid-packet discards the partial packet; the next accepted beat starts a new packet.
- Stall rule: stall = axis_in_tlast & desc_full, where desc_full is occupancy == DESC_DEPTH from the registered count.
  - A pop in the same cycle does NOT release the stall.
- Passthrough is combinational, zero latency:
  - body tdata/tkeep/tlast = in.
  - axis_body_tvalid = axis_in_tvalid & ~stall.
  - axis_in_tready = axis_body_tready & ~stall.
- Beat accepted (acc): axis_in_tvalid & axis_in_tready.
- Per-beat count: beat_bytes = popcount(tkeep), 0..DW/8. Any tkeep bit position counts; no contiguity check.
- Running length: len_now = accumulator + beat_bytes, computed LEN_W+1 wide and saturated to 2^LEN_W−1. The saturated flag is set if the true sum exceeds the maximum.
- On acc & ~tlast: accumulator ← len_now. The sticky sat and null flags OR in the current saturation and (beat_bytes==0).
- On acc & tlast:
  - Push descriptor {null, giant, runt, len_now}:
    - null = sticky_null | (beat_bytes==0).
    - runt = len_now < MIN_LEN.
    - giant = (len_now > MAX_LEN) | sat_sticky | sat_now.
  - Clear accumulator and sticky flags.
  - A single-beat packet is valid; its length is that beat's popcount.
- Descriptor FIFO: first-word-fall-through.
  - axis_desc_tvalid = not empty; tdata = head entry.
  - Pop on tvalid & tready.
  - Simultaneous push and pop: occupancy unchanged; the pushed entry is written behind the head.
  - Pointers wrap modulo DESC_DEPTH. Overflow is impossible by the stall rule.
- Statistics, per cycle:
  - On acc, byte_count += beat_bytes.
  - On acc & tlast, pkt_count += 1.
  - Both wrap at 2^32.
  - stat_clear has priority: both counters ← 0 and the same-cycle increment is lost.
  - stat_clear does not affect the FIFO or the accumulator.
- Backpressure on body (tready=0): no state change.
  - The bench ensures tvalid/tdata are held stable per AXI-S; the block does not check this.

Test Plan:
- Three beats, tkeep all-ones (DW=128), then tlast with tkeep=0x00FF → descriptor length=56, runt=1, giant=0, null=0; pkt_count=1, byte_count=56.
- 100 full beats (1600 bytes) with tlast → length=1600, giant=1, runt=0. Then one packet of 64 bytes → length=64, runt=0, giant=0.
- Hold axis_desc_tready=0; send 9 single-beat packets (DESC_DEPTH=8) → desc_level=8. The 9th tlast beat sees axis_in_tready=0 and axis_body_tvalid=0. Assert desc_tready for one pop → the beat is accepted on the following cycle. All 9 descriptors drain in order with the correct lengths.
- LEN_W=8 build: 20 full 16-byte beats → length=255 and giant=1. Next packet starts from 0.
- Middle beat with tkeep=0 inside a 3-beat packet → null=1, length equals the sum of the other two beats. Next packet null=0.
- Reset asserted mid-packet after 2 beats, then a fresh 1-beat packet with tkeep=0x000F → length=4, pkt_count=1, FIFO contains exactly 1 entry.
- stat_clear pulsed on the same cycle as a tlast acceptance → pkt_count=0, byte_count=0, and the descriptor is still pushed.
